rsa_operand_loader: RTL and testbench
=====================================

// Module: rsa_operand_loader
// PURPOSE
// - Write side of the RSA operand registers: receives 1024-bit DMA words and stores them into the operand slots consumed by rsa_hw.
// - Slots: N, R mod N, R^2 mod N, M, exponent, exponent length.
// - Sits between the DMA rx channel and rsa_hw.
// - Owns the rx half of the DMA handshake. Reports per-slot valid bits and an error flag to the CPU status word.
// PARAMETERS
// DATA_W   1024  width of a DMA word and of each operand slot
// LEN_W    32    width of the exponent-length slot
// PORTS
// clk             in   1       system clock
// resetn          in   1       asynchronous active-low reset
// load_sel        in   4       CPU load command: 0 idle, 1 N, 2 RmodN, 3 R2modN, 4 M, 5 exponent, 6 t_len, 7 clear-all
// compute_busy    in   1       rsa_hw computing; operand writes forbidden
// dma_idle        in   1       DMA engine idle
// dma_done        in   1       one-cycle pulse: rx transfer complete
// dma_error       in   1       rx transfer failed; sampled with dma_done
// dma_rx_data     in   DATA_W  received word, valid while dma_done=1
// dma_rx_start    out  1       one-cycle pulse starting an rx transfer
// N_Q             out  DATA_W  modulus slot
// R_N_Q           out  DATA_W  R mod N slot
// R2_N_Q          out  DATA_W  R^2 mod N slot
// M_Q             out  DATA_W  message slot
// E_Q             out  DATA_W  exponent slot
// t_len_Q         out  LEN_W   exponent bit length
// operands_ready  out  1       all six valid bits set
// status          out  32     {18'b0, last_sel[3:0], err, valid[5:0], operands_ready, is_idle, is_done}
// BEHAVIOUR
// - Reset (async): all slots, valid, err, and last_sel go to 0. dma_rx_start=0. State=IDLE. A reset mid-transfer abandons it; a later dma_done is ignored in IDLE.
// - FSM states: IDLE, RX, RX_WAIT, STORE, DONE.
//   - IDLE:
//     - load_sel in 1..6 and compute_busy=0 -> RX.
//     - load_sel=7 and compute_busy=0 -> clear valid[5:0], go to DONE.
//     - load_sel 8..15, or nonzero with compute_busy=1 -> set err, go to DONE. No DMA is started.
//     - load_sel=0 -> stay.
//     - Any nonzero command latches last_sel.
//   - RX: wait for dma_idle=1, then assert dma_rx_start for exactly one cycle and go to RX_WAIT.
//   - RX_WAIT: hold until dma_done.
//     - dma_done with dma_error=1 -> err=1, nothing written, go to DONE. Error wins over data.
//     - dma_done with dma_error=0 -> register the word, go to STORE.
//   - STORE (1 cycle): write the registered word to the slot selected by last_sel and set its valid bit; clear err; go to DONE.
//     - Slot 6 stores word[LEN_W-1:0] only if 1 <= value <= DATA_W. Otherwise set err and leave the slot and its valid bit unchanged.
//   - DONE: stay while load_sel != 0; go to IDLE when load_sel == 0. This prevents re-triggering from a stale command.
// - Latency: slot outputs update 2 cycles after the dma_done cycle (register, STORE). status reflects the update on the same edge.
// - Overwriting a valid slot is legal: new value, valid stays 1.
// - err is sticky until the next successful STORE or reset.
// - compute_busy rising while in RX/RX_WAIT: the transfer completes and is stored. The check happens only at command acceptance.
// - Slot outputs are registers, stable except on the STORE edge or reset.
// - is_idle=(state==IDLE), is_done=(state==DONE).
// STRUCTURE
// - Shared header rsa_defs.vh holds:
//   - load_sel codes: LD_NONE, LD_N, LD_RN, LD_R2N, LD_M, LD_E, LD_TLEN, LD_CLR.
//   - Loader state encodings.
//   - The status bit positions, also used by rsa_hw and the software driver.
// - Single module, no sub-modules. The slot write decode is a case on last_sel.
// TESTING
// - Reset, then load_sel=1 with dma_idle=1 -> one-cycle dma_rx_start. dma_done with data 0xABCD -> N_Q=0xABCD after 2 cycles, valid[0]=1, is_done=1. load_sel=0 -> is_idle=1.
// - Load all six slots (t_len=1024) -> operands_ready=1, status[8:3]=6'b111111. Then load_sel=7 -> valid=0, operands_ready=0, slot data retained.
// - load_sel=4 while dma_idle=0 for 5 cycles -> no dma_rx_start until dma_idle=1, then exactly one pulse.
// - dma_done with dma_error=1 on an M load -> M_Q unchanged, valid[3] unchanged, err=1. The next good load clears err.
// - t_len word=0 and word=1025 -> err=1, t_len_Q unchanged. Word=17 -> t_len_Q=17, err=0.
// - compute_busy=1 with load_sel=2 -> no DMA, err=1, DONE.
// - Assert resetn=0 in RX_WAIT -> all outputs 0; a subsequent dma_done is ignored and the FSM stays in IDLE.

Source files
------------

// File: rtl/rsa_operand_loader_pkg.sv
// Shared definitions for the RSA operand loader: command codes, FSM states,
// status word bit positions and the slot decode helper.
package rsa_operand_loader_pkg;

   localparam logic [3:0] LD_NONE = 4'd0;
   localparam logic [3:0] LD_N    = 4'd1;
   localparam logic [3:0] LD_RN   = 4'd2;
   localparam logic [3:0] LD_R2N  = 4'd3;
   localparam logic [3:0] LD_M    = 4'd4;
   localparam logic [3:0] LD_E    = 4'd5;
   localparam logic [3:0] LD_TLEN = 4'd6;
   localparam logic [3:0] LD_CLR  = 4'd7;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RX      = 3'd1,
      ST_RX_WAIT = 3'd2,
      ST_STORE   = 3'd3,
      ST_DONE    = 3'd4
   } ld_state_e;

   // Status word layout, shared with rsa_hw and the software driver
   localparam int unsigned STAT_DONE     = 0;
   localparam int unsigned STAT_IDLE     = 1;
   localparam int unsigned STAT_READY    = 2;
   localparam int unsigned STAT_VALID_LO = 3;
   localparam int unsigned STAT_ERR      = 9;
   localparam int unsigned STAT_SEL_LO   = 10;

   function automatic logic [5:0] slot_onehot(input logic [3:0] sel);
      logic [5:0] oh;
      case (sel)
         LD_N:    oh = 6'b000001;
         LD_RN:   oh = 6'b000010;
         LD_R2N:  oh = 6'b000100;
         LD_M:    oh = 6'b001000;
         LD_E:    oh = 6'b010000;
         LD_TLEN: oh = 6'b100000;
         default: oh = 6'b000000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/rsa_operand_loader.sv
// Write side of the RSA operand registers: fetches 1024-bit words over the DMA
// rx channel and stores them into the operand slots read by rsa_hw.
module rsa_operand_loader
   import rsa_operand_loader_pkg::*;
#(
   parameter int DATA_W = 1024,
   parameter int LEN_W  = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [3:0]        load_sel,
   input  logic              compute_busy,
   input  logic              dma_idle,
   input  logic              dma_done,
   input  logic              dma_error,
   input  logic [DATA_W-1:0] dma_rx_data,
   output logic              dma_rx_start,
   output logic [DATA_W-1:0] N_Q,
   output logic [DATA_W-1:0] R_N_Q,
   output logic [DATA_W-1:0] R2_N_Q,
   output logic [DATA_W-1:0] M_Q,
   output logic [DATA_W-1:0] E_Q,
   output logic [LEN_W-1:0]  t_len_Q,
   output logic              operands_ready,
   output logic [31:0]       status
);

   ld_state_e         state_r;
   ld_state_e         next_state_s;
   logic [3:0]        last_sel_r;
   logic              err_r;
   logic [5:0]        valid_r;
   logic [DATA_W-1:0] word_r;
   logic              dma_rx_start_r;

   logic              latch_sel_s;
   logic              clr_valid_s;
   logic              set_err_s;
   logic              start_s;
   logic              capture_s;
   logic              store_s;
   logic              tlen_ok_s;
   logic              store_bad_s;
   logic [5:0]        slot_we_s;

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and per-state control strobes
   always_comb begin
      next_state_s = state_r;
      latch_sel_s  = 1'b0;
      clr_valid_s  = 1'b0;
      set_err_s    = 1'b0;
      start_s      = 1'b0;
      capture_s    = 1'b0;
      store_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (load_sel != LD_NONE) begin
               latch_sel_s = 1'b1;
               if (compute_busy || (load_sel > LD_CLR)) begin
                  set_err_s    = 1'b1;
                  next_state_s = ST_DONE;
               end else if (load_sel == LD_CLR) begin
                  clr_valid_s  = 1'b1;
                  next_state_s = ST_DONE;
               end else begin
                  next_state_s = ST_RX;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RX: begin
            if (dma_idle) begin
               start_s      = 1'b1;
               next_state_s = ST_RX_WAIT;
            end else begin
               next_state_s = ST_RX;
            end
         end
         ST_RX_WAIT: begin
            if (dma_done) begin
               // A failed transfer never reaches the slots, whatever the data
               if (dma_error) begin
                  set_err_s    = 1'b1;
                  next_state_s = ST_DONE;
               end else begin
                  capture_s    = 1'b1;
                  next_state_s = ST_STORE;
               end
            end else begin
               next_state_s = ST_RX_WAIT;
            end
         end
         ST_STORE: begin
            store_s      = 1'b1;
            next_state_s = ST_DONE;
         end
         ST_DONE: begin
            if (load_sel == LD_NONE) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_DONE;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   assign tlen_ok_s = (word_r[LEN_W-1:0] != {LEN_W{1'b0}}) &&
                      (word_r[LEN_W-1:0] <= LEN_W'(DATA_W));

   // Slot write enables from the latched command
   always_comb begin
      slot_we_s   = 6'b000000;
      store_bad_s = 1'b0;
      if (store_s) begin
         case (last_sel_r)
            LD_N, LD_RN, LD_R2N, LD_M, LD_E: begin
               slot_we_s = slot_onehot(last_sel_r);
            end
            LD_TLEN: begin
               if (tlen_ok_s) begin
                  slot_we_s = slot_onehot(last_sel_r);
               end else begin
                  store_bad_s = 1'b1;
               end
            end
            default: begin
               slot_we_s = 6'b000000;
            end
         endcase
      end else begin
         slot_we_s   = 6'b000000;
         store_bad_s = 1'b0;
      end
   end

   // Command latch, sticky error, valid bits, capture register, start pulse
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_sel_r     <= 4'd0;
         err_r          <= 1'b0;
         valid_r        <= 6'b000000;
         word_r         <= {DATA_W{1'b0}};
         dma_rx_start_r <= 1'b0;
      end else begin
         dma_rx_start_r <= start_s;
         if (latch_sel_s) begin
            last_sel_r <= load_sel;
         end
         if (capture_s) begin
            word_r <= dma_rx_data;
         end
         if (set_err_s || store_bad_s) begin
            err_r <= 1'b1;
         end else if (store_s) begin
            err_r <= 1'b0;
         end
         if (clr_valid_s) begin
            valid_r <= 6'b000000;
         end else begin
            valid_r <= valid_r | slot_we_s;
         end
      end
   end

   // Operand slot registers; only the STORE edge touches them
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         N_Q     <= {DATA_W{1'b0}};
         R_N_Q   <= {DATA_W{1'b0}};
         R2_N_Q  <= {DATA_W{1'b0}};
         M_Q     <= {DATA_W{1'b0}};
         E_Q     <= {DATA_W{1'b0}};
         t_len_Q <= {LEN_W{1'b0}};
      end else begin
         if (slot_we_s[0]) N_Q     <= word_r;
         if (slot_we_s[1]) R_N_Q   <= word_r;
         if (slot_we_s[2]) R2_N_Q  <= word_r;
         if (slot_we_s[3]) M_Q     <= word_r;
         if (slot_we_s[4]) E_Q     <= word_r;
         if (slot_we_s[5]) t_len_Q <= word_r[LEN_W-1:0];
      end
   end

   assign dma_rx_start   = dma_rx_start_r;
   assign operands_ready = &valid_r;

   always_comb begin
      status                                    = 32'd0;
      status[STAT_DONE]                         = (state_r == ST_DONE);
      status[STAT_IDLE]                         = (state_r == ST_IDLE);
      status[STAT_READY]                        = operands_ready;
      status[STAT_VALID_LO +: 6]                = valid_r;
      status[STAT_ERR]                          = err_r;
      status[STAT_SEL_LO +: 4]                  = last_sel_r;
   end

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Directed bench for rsa_operand_loader: a transaction-level model of the
// operand slots and status fields is compared against the DUT every cycle.
module tb_rsa_operand_loader;

   logic          clk;
   logic          resetn;
   logic [3:0]    load_sel;
   logic          compute_busy;
   logic          dma_idle;
   logic          dma_done;
   logic          dma_error;
   logic [1023:0] dma_rx_data;
   logic          dma_rx_start;
   logic [1023:0] N_Q, R_N_Q, R2_N_Q, M_Q, E_Q;
   logic [31:0]   t_len_Q;
   logic          operands_ready;
   logic [31:0]   status;

   rsa_operand_loader #(.DATA_W(1024), .LEN_W(32)) dut (
      .clk(clk), .resetn(resetn), .load_sel(load_sel), .compute_busy(compute_busy),
      .dma_idle(dma_idle), .dma_done(dma_done), .dma_error(dma_error),
      .dma_rx_data(dma_rx_data), .dma_rx_start(dma_rx_start),
      .N_Q(N_Q), .R_N_Q(R_N_Q), .R2_N_Q(R2_N_Q), .M_Q(M_Q), .E_Q(E_Q),
      .t_len_Q(t_len_Q), .operands_ready(operands_ready), .status(status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_chk  = 0;
   int            n_fail = 0;
   int            pulse_cnt = 0;
   bit            chk_en = 1'b0;

   // Model: slot contents, valid bits, sticky error and last command
   logic [1023:0] m_slot [6];
   logic [5:0]    m_valid;
   logic          m_err;
   logic [3:0]    m_last;

   localparam logic [1023:0] M_DATA = {1'b1, 1023'h5A5A_0000_1234};

   task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0h exp=%0h", name, act[127:0], exp[127:0]);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 6; i++) m_slot[i] = 1024'd0;
      m_valid = 6'd0;
      m_err   = 1'b0;
      m_last  = 4'd0;
   endtask

   task automatic model_store(input logic [3:0] sel, input logic [1023:0] data);
      logic [31:0] v;
      if (sel == 4'd6) begin
         v = data[31:0];
         if (v >= 32'd1 && v <= 32'd1024) begin
            m_slot[5]  = 1024'(v);
            m_valid[5] = 1'b1;
            m_err      = 1'b0;
         end else begin
            m_err = 1'b1;
         end
      end else begin
         m_slot[sel - 4'd1]  = data;
         m_valid[sel - 4'd1] = 1'b1;
         m_err               = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (dma_rx_start) pulse_cnt++;
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("N_Q", N_Q, m_slot[0]);
         chk("R_N_Q", R_N_Q, m_slot[1]);
         chk("R2_N_Q", R2_N_Q, m_slot[2]);
         chk("M_Q", M_Q, m_slot[3]);
         chk("E_Q", E_Q, m_slot[4]);
         chk("t_len_Q", 1024'(t_len_Q), m_slot[5]);
         chk("valid", 1024'(status[8:3]), 1024'(m_valid));
         chk("err", 1024'(status[9]), 1024'(m_err));
         chk("last_sel", 1024'(status[13:10]), 1024'(m_last));
         chk("ready", 1024'(status[2]), 1024'(&m_valid));
         chk("ready_port", 1024'(operands_ready), 1024'(&m_valid));
         chk("status_hi", 1024'(status[31:14]), 1024'd0);
      end
   end

   task automatic wait_pulse(input int p0, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         if (pulse_cnt != p0) seen = 1'b1;
      end
      chk("start_seen", 1024'(seen), 1024'd1);
   endtask

   task automatic do_load(input logic [3:0] sel, input logic [1023:0] data,
                          input logic err_in, input int idle_delay);
      int p0;
      bit seen;
      @(posedge clk); #1;
      load_sel = sel;
      dma_idle = (idle_delay == 0);
      p0 = pulse_cnt;
      @(posedge clk); #1;
      m_last = sel;
      for (int i = 0; i < idle_delay; i++) begin
         @(posedge clk); #1;
      end
      if (idle_delay > 0) chk("no_start_dma_busy", 1024'(pulse_cnt - p0), 1024'd0);
      dma_idle = 1'b1;
      wait_pulse(p0, seen);
      dma_done = 1'b1; dma_error = err_in; dma_rx_data = data;
      @(posedge clk); #1;
      dma_done = 1'b0; dma_error = 1'b0; dma_rx_data = 1024'd0;
      if (err_in) begin
         m_err = 1'b1;
      end else begin
         @(posedge clk); #1;
         model_store(sel, data);
      end
      chk("start_pulses", 1024'(pulse_cnt - p0), 1024'd1);
      chk("is_done", 1024'(status[0]), 1024'd1);
      load_sel = 4'd0;
      @(posedge clk); #1;
      chk("is_idle", 1024'(status[1]), 1024'd1);
   endtask

   task automatic do_cmd(input logic [3:0] sel, input logic busy);
      int p0;
      @(posedge clk); #1;
      load_sel = sel; compute_busy = busy;
      p0 = pulse_cnt;
      @(posedge clk); #1;
      m_last = sel;
      if (sel == 4'd7 && !busy) m_valid = 6'd0;
      else m_err = 1'b1;
      compute_busy = 1'b0;
      chk("cmd_done", 1024'(status[0]), 1024'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("cmd_hold_done", 1024'(status[0]), 1024'd1);
      chk("cmd_no_dma", 1024'(pulse_cnt - p0), 1024'd0);
      load_sel = 4'd0;
      @(posedge clk); #1;
      chk("cmd_idle", 1024'(status[1]), 1024'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int  p0;
      bit  seen;
      resetn = 1'b0; load_sel = 4'd0; compute_busy = 1'b0; dma_idle = 1'b1;
      dma_done = 1'b0; dma_error = 1'b0; dma_rx_data = 1024'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_N_Q", N_Q, 1024'd0);
      chk("rst_status", 1024'(status), 1024'h2);
      chk("rst_start", 1024'(dma_rx_start), 1024'd0);
      resetn = 1'b1;
      chk_en = 1'b1;

      // First N load, then literal pins on the model
      do_load(4'd1, 1024'hABCD, 1'b0, 0);
      chk("lit_N", N_Q, 1024'hABCD);
      chk("lit_valid0", 1024'(status[3]), 1024'd1);

      do_load(4'd2, 1024'h1111_2222, 1'b0, 0);
      do_load(4'd3, 1024'h3333_4444_5555, 1'b0, 0);
      do_load(4'd4, M_DATA, 1'b0, 5);
      do_load(4'd5, 1024'h10001, 1'b0, 0);
      do_load(4'd6, 1024'd1024, 1'b0, 0);
      chk("lit_ready", 1024'(operands_ready), 1024'd1);
      chk("lit_valid_all", 1024'(status[8:3]), 1024'h3F);
      chk("lit_tlen", 1024'(t_len_Q), 1024'd1024);

      // Clear-all keeps data
      do_cmd(4'd7, 1'b0);
      chk("lit_clr_valid", 1024'(status[8:3]), 1024'd0);
      chk("lit_clr_N", N_Q, 1024'hABCD);

      // Overwrite M, then a failed M transfer must leave it alone
      do_load(4'd4, 1024'h77, 1'b0, 0);
      do_load(4'd4, 1024'hDEAD, 1'b1, 0);
      chk("lit_err_M", M_Q, 1024'h77);
      chk("lit_err_set", 1024'(status[9]), 1024'd1);
      do_load(4'd5, 1024'h3, 1'b0, 0);
      chk("lit_err_clr", 1024'(status[9]), 1024'd0);

      // Exponent-length range limits
      do_load(4'd6, 1024'd0, 1'b0, 0);
      do_load(4'd6, 1024'd1025, 1'b0, 0);
      chk("lit_tlen_bad", 1024'(t_len_Q), 1024'd1024);
      chk("lit_tlen_err", 1024'(status[9]), 1024'd1);
      do_load(4'd6, 1024'd17, 1'b0, 0);
      chk("lit_tlen17", 1024'(t_len_Q), 1024'd17);
      do_load(4'd6, 1024'd1, 1'b0, 0);

      // Rejected commands
      do_cmd(4'd2, 1'b1);
      do_cmd(4'd9, 1'b0);
      chk("lit_bad_sel", 1024'(status[13:10]), 1024'd9);

      // Reset while waiting for dma_done
      @(posedge clk); #1;
      load_sel = 4'd1;
      p0 = pulse_cnt;
      @(posedge clk); #1;
      m_last = 4'd1;
      wait_pulse(p0, seen);
      resetn = 1'b0; load_sel = 4'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst2_status", 1024'(status), 1024'h2);
      chk("rst2_N", N_Q, 1024'd0);
      resetn = 1'b1;
      p0 = pulse_cnt;
      @(posedge clk); #1;
      dma_done = 1'b1; dma_rx_data = 1024'h55;
      @(posedge clk); #1;
      dma_done = 1'b0; dma_rx_data = 1024'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst2_idle", 1024'(status[1]), 1024'd1);
      chk("rst2_no_dma", 1024'(pulse_cnt - p0), 1024'd0);

      @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
